// File: rtl/wb_host_bridge.sv
// Single-byte request to Wishbone classic bridge for the jacaranda-8 core.
// One outstanding transfer; a timeout counter aborts cycles that never get acked.
module wb_host_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on an edge where req_valid_i && req_ready_o;
    // the core holds the request until then. rsp_valid_o is a one-cycle strobe.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ready_q, ready_nxt;
    logic             cyc_q, cyc_nxt;
    logic             we_q, we_nxt;
    logic [31:0]      adr_q, adr_nxt;
    logic [31:0]      dat_q, dat_nxt;
    logic [3:0]       sel_q, sel_nxt;
    logic [1:0]       lane_q, lane_nxt;
    logic             rsp_valid_q, rsp_valid_nxt;
    logic [7:0]       rdata_q, rdata_nxt;
    logic             err_q, err_nxt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_q     <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            lane_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ready_q     <= ready_nxt;
            cyc_q       <= cyc_nxt;
            we_q        <= we_nxt;
            adr_q       <= adr_nxt;
            dat_q       <= dat_nxt;
            sel_q       <= sel_nxt;
            lane_q      <= lane_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rdata_q     <= rdata_nxt;
            err_q       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ready_nxt     = ready_q;
        cyc_nxt       = cyc_q;
        we_nxt        = we_q;
        adr_nxt       = adr_q;
        dat_nxt       = dat_q;
        sel_nxt       = sel_q;
        lane_nxt      = lane_q;
        rsp_valid_nxt = rsp_valid_q;
        rdata_nxt     = rdata_q;
        err_nxt       = err_q;

        case (state)
            IDLE: begin
                if (req_valid_i && ready_q) begin
                    ready_nxt = 1'b0;
                    cyc_nxt   = 1'b1;
                    we_nxt    = req_we_i;
                    adr_nxt   = {req_addr_i[31:2], 2'b00};
                    sel_nxt   = 4'b0001 << req_addr_i[1:0];
                    lane_nxt  = req_addr_i[1:0];
                    dat_nxt   = req_we_i ? {4{req_wdata_i}} : 32'd0;
                    cnt_nxt   = '0;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so an ack on the last allowed cycle still completes.
                if (wbm_ack_i) begin
                    cyc_nxt       = 1'b0;
                    we_nxt        = 1'b0;
                    rdata_nxt     = we_q ? 8'd0 : wbm_dat_i[{lane_q, 3'b000} +: 8];
                    err_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    cyc_nxt       = 1'b0;
                    we_nxt        = 1'b0;
                    rdata_nxt     = 8'd0;
                    err_nxt       = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                rsp_valid_nxt = 1'b0;
                ready_nxt     = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
                cyc_nxt   = 1'b0;
            end
        endcase
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench for wb_host_bridge: byte lanes, wait states, timeout, reset abort
// and back-to-back requests, all against hand-computed expected values.
module tb_wb_host_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_wdata_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_rdata_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    wb_host_bridge #(.TIMEOUT(255), .CNT_W(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // waits < 0: never ack (expects the timeout abort after 255 cycles).
    task automatic run_xfer(input logic we, input logic [31:0] addr, input logic [7:0] wdata,
                            input logic [31:0] rdin, input int waits,
                            input logic [7:0] exp_rdata, input logic exp_err, input logic stray);
        int cyc_cnt;
        int guard;
        logic [3:0] exp_sel;
        exp_sel = 4'b0001 << addr[1:0];
        check("ready_before_req", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        tick;
        req_valid_i = 1'b0;
        check("cyc_after_accept", 32'(wbm_cyc_o), 32'd1);
        check("stb_after_accept", 32'(wbm_stb_o), 32'd1);
        check("ready_low_in_bus", 32'(req_ready_o), 32'd0);
        check("we", 32'(wbm_we_o), 32'(we));
        check("adr", wbm_adr_o, {addr[31:2], 2'b00});
        check("sel", 32'(wbm_sel_o), 32'(exp_sel));
        check("dat_o", wbm_dat_o, we ? {4{wdata}} : 32'd0);
        cyc_cnt = 0;
        guard   = 0;
        while (wbm_cyc_o && guard < 400) begin
            cyc_cnt++;
            guard++;
            wbm_dat_i = rdin;
            wbm_ack_i = (waits >= 0) && (cyc_cnt == waits + 1);
            tick;
        end
        wbm_ack_i = 1'b0;
        check("cycle_guard", 32'(guard < 400), 32'd1);
        check("cyc_high_cycles", 32'(cyc_cnt), (waits >= 0) ? 32'(waits + 1) : 32'd255);
        check("stb_low_after", 32'(wbm_stb_o), 32'd0);
        check("rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
        check("rsp_rdata", 32'(rsp_rdata_o), 32'(exp_rdata));
        check("ready_low_in_resp", 32'(req_ready_o), 32'd0);
        wbm_ack_i = stray;
        tick;
        wbm_ack_i = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid_o), 32'd0);
        check("ready_back", 32'(req_ready_o), 32'd1);
        check("rdata_hold", 32'(rsp_rdata_o), 32'(exp_rdata));
        check("err_hold", 32'(rsp_err_o), 32'(exp_err));
        tick;
        check("no_extra_rsp", 32'(rsp_valid_o), 32'd0);
        check("idle_cyc", 32'(wbm_cyc_o), 32'd0);
    endtask

    initial begin
        int first_acc;
        int second_acc;
        int accepts;
        int rsps;
        logic acc;

        rst = 1'b1;
        req_valid_i = 1'b0;
        req_we_i = 1'b0;
        req_addr_i = '0;
        req_wdata_i = '0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;

        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(wbm_stb_o), 32'd0);
        check("rst_we", 32'(wbm_we_o), 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_dat", wbm_dat_o, 32'd0);
        check("rst_sel", 32'(wbm_sel_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rdata", 32'(rsp_rdata_o), 32'd0);
        check("rst_err", 32'(rsp_err_o), 32'd0);

        // Write, lane 1, ack one cycle after stb rises.
        run_xfer(1'b1, 32'h3000_0001, 8'hA5, 32'hFFFF_FFFF, 1, 8'h00, 1'b0, 1'b0);
        // Reads of each lane with three wait states.
        run_xfer(1'b0, 32'h3000_0003, 8'h00, 32'h1234_5678, 3, 8'h12, 1'b0, 1'b0);
        run_xfer(1'b0, 32'h3000_0000, 8'h00, 32'h1234_5678, 3, 8'h78, 1'b0, 1'b0);
        run_xfer(1'b0, 32'h3000_0001, 8'h00, 32'h1234_5678, 3, 8'h56, 1'b0, 1'b0);
        run_xfer(1'b0, 32'h3000_0002, 8'h00, 32'h1234_5678, 3, 8'h34, 1'b0, 1'b1);
        // Timeout abort, then ack on the final allowed cycle.
        run_xfer(1'b0, 32'h4000_0002, 8'h00, 32'hCAFE_BABE, -1, 8'h00, 1'b1, 1'b0);
        run_xfer(1'b0, 32'h4000_0002, 8'h00, 32'hCAFE_BABE, 254, 8'hFE, 1'b0, 1'b0);

        // Reset during the second cycle of a bus cycle.
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h5000_0000;
        tick;
        req_valid_i = 1'b0;
        check("rstbus_cyc_up", 32'(wbm_cyc_o), 32'd1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rstbus_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rstbus_stb", 32'(wbm_stb_o), 32'd0);
        check("rstbus_ready", 32'(req_ready_o), 32'd1);
        check("rstbus_no_rsp", 32'(rsp_valid_o), 32'd0);
        wbm_ack_i = 1'b1;
        tick;
        wbm_ack_i = 1'b0;
        check("stray_ack_no_rsp", 32'(rsp_valid_o), 32'd0);
        check("stray_ack_no_cyc", 32'(wbm_cyc_o), 32'd0);
        check("stray_ack_ready", 32'(req_ready_o), 32'd1);
        tick;
        check("stray_ack_no_rsp2", 32'(rsp_valid_o), 32'd0);
        run_xfer(1'b1, 32'h5000_0003, 8'h3C, 32'h0, 0, 8'h00, 1'b0, 1'b0);

        // Back-to-back with req_valid_i held high; acks also offered during RESP.
        first_acc  = -1;
        second_acc = -1;
        accepts    = 0;
        rsps       = 0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h1000_0002;
        req_wdata_i = 8'h55;
        wbm_dat_i   = 32'h0000_AB00;
        for (int c = 0; c < 10; c++) begin
            wbm_ack_i = wbm_cyc_o || rsp_valid_o;
            if (rsp_valid_o) begin
                rsps++;
                if (rsps == 1) check("b2b_rdata1", 32'(rsp_rdata_o), 32'h00);
                else           check("b2b_rdata2", 32'(rsp_rdata_o), 32'hAB);
            end
            acc = req_valid_i && req_ready_o;
            if (acc) begin
                accepts++;
                if (accepts == 1) first_acc = c;
                else              second_acc = c;
            end
            tick;
            if (acc) begin
                if (accepts == 1) begin
                    check("b2b_dat1", wbm_dat_o, 32'h5555_5555);
                    req_we_i    = 1'b0;
                    req_addr_i  = 32'h1000_0001;
                    req_wdata_i = 8'h00;
                end else begin
                    check("b2b_sel2", 32'(wbm_sel_o), 32'b0010);
                    req_valid_i = 1'b0;
                end
            end
        end
        wbm_ack_i = 1'b0;
        check("b2b_accepts", 32'(accepts), 32'd2);
        check("b2b_spacing", 32'(second_acc - first_acc), 32'd3);
        check("b2b_rsps", 32'(rsps), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
